// File: rtl/mul_issue.sv
// Issue stage for an external two-cycle multiplier: operand setup, result tag tracking,
// credit-limited request acceptance and an in-order response FIFO.
module mul_issue #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pause,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    output logic        mul_en,
    output logic        mac_low,
    output logic        mac_high,
    output logic [32:0] din1,
    output logic [32:0] din2,
    input  logic [31:0] dlout,
    input  logic [31:0] dhout,
    input  logic        vldout,
    input  logic        vhdout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    // tag pipe: stage 1 holds any issued op, stage 2 only high ops still awaiting vhdout
    logic        t1_v;
    logic        t1_hi;
    logic [4:0]  t1_rd;
    logic        t2_v;
    logic [4:0]  t2_rd;

    logic [36:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          high_req;
    logic          issue;
    logic          sgn1;
    logic          sgn2;
    logic [CW:0]   credits_used;
    logic          push_lo;
    logic          push_hi;
    logic          push;
    logic          do_push;
    logic          pop;
    logic          full;
    logic [36:0]   push_word;
    logic [36:0]   head;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        high_req     = (req_op != OP_MUL);
        credits_used = {1'b0, count} + (CW+1)'(t1_v) + (CW+1)'(t2_v);
        // a MUL right behind a high op would return its low result alongside the high one
        req_ready    = !reset && !pause && !flush
                       && (credits_used < (CW+1)'(FIFO_DEPTH))
                       && !(t1_v && t1_hi && !high_req);
        issue        = req_valid && req_ready;
        mul_en       = issue;
        mac_low      = issue && !high_req;
        mac_high     = issue && high_req;
        sgn1         = (req_op == OP_MULH) || (req_op == OP_MULHSU);
        sgn2         = (req_op == OP_MULH);
        din1         = issue ? {sgn1 & req_rs1[31], req_rs1} : '0;
        din2         = issue ? {sgn2 & req_rs2[31], req_rs2} : '0;
    end

    always_comb begin
        push_lo   = vldout && !pause && t1_v && !t1_hi;
        push_hi   = vhdout && !pause && t2_v;
        push      = push_lo || push_hi;
        push_word = push_hi ? {dhout, t2_rd} : {dlout, t1_rd};
        full      = (count == CW'(FIFO_DEPTH));
        rsp_valid = (count != '0);
        pop       = rsp_valid && rsp_ready;
        do_push   = push && (!full || pop);
        head      = mem[rd_ptr];
        rsp_data  = rsp_valid ? head[36:5] : '0;
        rsp_rd    = rsp_valid ? head[4:0]  : '0;
        busy      = t1_v || t2_v || rsp_valid;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            t1_v  <= 1'b0;
            t1_hi <= 1'b0;
            t1_rd <= '0;
            t2_v  <= 1'b0;
            t2_rd <= '0;
        end else if (!pause) begin
            t1_v  <= issue;
            t1_hi <= high_req;
            t1_rd <= req_rd;
            t2_v  <= t1_v && t1_hi;
            t2_rd <= t1_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) mem[wr_ptr] <= push_word;
    end

endmodule

// File: tb/tb_mul_issue.sv
// Bench for mul_issue: emulated two-cycle multiplier, reference response queue, directed cases.
module tb_mul_issue;

    logic        clk = 1'b0;
    logic        reset, pause, flush;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1, req_rs2;
    logic [4:0]  req_rd;
    logic        mul_en, mac_low, mac_high;
    logic [32:0] din1, din2;
    logic [31:0] dlout, dhout;
    logic        vldout, vhdout;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    mul_issue #(.FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .pause(pause), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .mul_en(mul_en), .mac_low(mac_low), .mac_high(mac_high),
        .din1(din1), .din2(din2), .dlout(dlout), .dhout(dhout),
        .vldout(vldout), .vhdout(vhdout), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // external multiplier: captured on the falling edge, advanced on rising edges without pause
    logic               cap_en = 1'b0, cap_lo = 1'b0;
    logic signed [65:0] cap_p = '0;
    logic               m1_v = 1'b0, m1_lo = 1'b0, m2_v = 1'b0;
    logic signed [65:0] m1_p = '0, m2_p = '0;
    logic signed [65:0] a66, b66;

    assign a66    = $signed(din1);
    assign b66    = $signed(din2);
    assign vldout = m1_v && m1_lo;
    assign dlout  = m1_p[31:0];
    assign vhdout = m2_v;
    assign dhout  = m2_p[63:32];

    always @(negedge clk) begin
        cap_en = mul_en;
        cap_lo = mac_low;
        cap_p  = a66 * b66;
    end

    always @(posedge clk) begin
        if (!pause) begin
            m1_v  <= cap_en;
            m1_lo <= cap_lo;
            m1_p  <= cap_p;
            m2_v  <= m1_v && !m1_lo;
            m2_p  <= m1_p;
        end
    end

    // reference: architectural result of each accepted request, in acceptance order
    typedef struct packed { logic [31:0] data; logic [4:0] rd; } rsp_t;
    rsp_t exp_q[$];

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            2'b00:   p = ua * ub;
            2'b01:   p = sa * sb;
            2'b10:   p = sa * ub;
            default: p = ua * ub;
        endcase
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    always @(negedge clk) begin
        rsp_t e;
        logic exp_s1, exp_s2, iss;
        iss    = req_valid && req_ready;
        exp_s1 = (req_op == 2'b01) || (req_op == 2'b10);
        exp_s2 = (req_op == 2'b01);
        if (pause || flush || reset) check("ready_blocked", req_ready, 0);
        check("mul_en", mul_en, iss);
        check("mac_low", mac_low, iss && req_op == 2'b00);
        check("mac_high", mac_high, iss && req_op != 2'b00);
        check("din1", din1, iss ? {exp_s1 & req_rs1[31], req_rs1} : 33'd0);
        check("din2", din2, iss ? {exp_s2 & req_rs2[31], req_rs2} : 33'd0);
        if (!reset) check("busy", busy, exp_q.size() != 0);
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {rsp_data, 27'd0, rsp_rd}, 64'hDEAD);
            end else begin
                e = exp_q[0];
                check("rsp_data", rsp_data, e.data);
                check("rsp_rd", rsp_rd, e.rd);
            end
        end else begin
            check("rsp_idle_zero", {rsp_data, rsp_rd}, 0);
        end
        if (reset || flush) exp_q.delete();
        else begin
            if (rsp_valid && rsp_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (mul_en) exp_q.push_back('{ref_result(req_op, req_rs1, req_rs2), req_rd});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        req_valid = v; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
    endtask

    task automatic expect_rsp(input string name, input logic [31:0] d, input logic [4:0] rd,
                              input int max_cycles);
        bit found = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                check({name, "_data"}, rsp_data, d);
                check({name, "_rd"}, rsp_rd, rd);
                found = 1;
                break;
            end
        end
        if (!found) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic hi_case(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic [31:0] d);
        drive(1, op, a, b, rd);
        @(negedge clk); check({name, "_ready"}, req_ready, 1);
        cyc(); drive(0, 0, 0, 0, 0);
        @(negedge clk); check({name, "_t1"}, rsp_valid, 0);
        cyc();
        @(negedge clk); check({name, "_t2"}, rsp_valid, 0);
        cyc();
        @(negedge clk);
        check({name, "_t3_valid"}, rsp_valid, 1);
        check({name, "_t3_data"}, rsp_data, d);
        check({name, "_t3_rd"}, rsp_rd, rd);
        cyc();
    endtask

    task automatic kill_case(input string name, input bit use_reset);
        drive(1, 2'b00, 32'd5, 32'd5, 5'd7);
        @(negedge clk); check({name, "_issue"}, req_ready, 1);
        cyc();
        if (use_reset) reset = 1; else flush = 1;
        drive(1, 2'b00, 32'd2, 32'd2, 5'd8);
        @(negedge clk); check({name, "_ready"}, req_ready, 0);
        cyc();
        reset = 0; flush = 0; drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check({name, "_busy"}, busy, 0);
        check({name, "_rsp"}, rsp_valid, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk); check({name, "_stale"}, rsp_valid, 0);
        end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        reset = 1; pause = 0; flush = 0; rsp_ready = 1;
        drive(1, 2'b00, 32'd1, 32'd1, 5'd1);
        cyc(); cyc();
        @(negedge clk);
        check("reset_ready", req_ready, 0);
        check("reset_mul_en", mul_en, 0);
        cyc(); reset = 0; drive(0, 0, 0, 0, 0);
        @(negedge clk);
        check("post_reset_rsp_valid", rsp_valid, 0);
        check("post_reset_busy", busy, 0);
        cyc();

        // MUL 7 x 0xFFFFFFFD, operand 2 zero-extended
        drive(1, 2'b00, 32'd7, 32'hFFFF_FFFD, 5'd5);
        @(negedge clk);
        check("mul_ready", req_ready, 1);
        check("mul_din2_msb", din2[32], 0);
        check("mul_din1", din1, 33'd7);
        cyc(); drive(0, 0, 0, 0, 0);
        @(negedge clk); check("mul_t1_valid", rsp_valid, 0);
        cyc();
        @(negedge clk);
        check("mul_t2_valid", rsp_valid, 1);
        check("mul_t2_data", rsp_data, 32'hFFFF_FFEB);
        check("mul_t2_rd", rsp_rd, 5'd5);
        cyc();

        hi_case("mulh", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd9, 32'h4000_0000);
        hi_case("mulhu", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE);
        hi_case("mulhsu", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFF);

        // MUL right behind MULHU must wait one cycle
        drive(1, 2'b11, 32'd3, 32'd5, 5'd1);
        @(negedge clk); check("hazard_hi_ready", req_ready, 1);
        cyc(); drive(1, 2'b00, 32'd6, 32'd7, 5'd2);
        @(negedge clk); check("hazard_mul_blocked", req_ready, 0);
        cyc();
        @(negedge clk); check("hazard_mul_accepted", req_ready, 1);
        cyc(); drive(0, 0, 0, 0, 0);
        expect_rsp("hazard_first", 32'd0, 5'd1, 6);
        cyc();
        expect_rsp("hazard_second", 32'd42, 5'd2, 4);
        cyc();

        // credit limit with a stalled consumer
        rsp_ready = 0; accepted = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 2'b00, 32'(i + 2), 32'd3, 5'(10 + i));
            @(negedge clk);
            if (mul_en) accepted++;
            if (i == 5) check("credit_ready_low", req_ready, 0);
            cyc();
        end
        check("credit_accepted", accepted, 2);
        drive(0, 0, 0, 0, 0); rsp_ready = 1;
        expect_rsp("drain_first", 32'd6, 5'd10, 4);
        cyc();
        expect_rsp("drain_second", 32'd9, 5'd11, 4);
        cyc();
        drive(1, 2'b00, 32'd4, 32'd3, 5'd12);
        @(negedge clk); check("resume_ready", req_ready, 1);
        cyc(); drive(0, 0, 0, 0, 0);
        expect_rsp("resume_rsp", 32'd12, 5'd12, 5);
        cyc();

        // pause for three cycles right after a MULH issue
        drive(1, 2'b01, 32'h4000_0000, 32'h10, 5'd3);
        @(negedge clk); check("pause_issue", req_ready, 1);
        cyc();
        pause = 1; drive(1, 2'b01, 32'd1, 32'd1, 5'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("pause_ready", req_ready, 0);
            check("pause_no_rsp", rsp_valid, 0);
            cyc();
        end
        pause = 0; drive(0, 0, 0, 0, 0);
        @(negedge clk); check("pause_t4", rsp_valid, 0);
        cyc();
        @(negedge clk); check("pause_t5", rsp_valid, 0);
        cyc();
        @(negedge clk);
        check("pause_t6_valid", rsp_valid, 1);
        check("pause_t6_data", rsp_data, 32'd4);
        cyc();

        kill_case("flush", 0);
        kill_case("midreset", 1);

        for (int i = 0; i < 4; i++) cyc();
        check("model_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mul_issue.md
MUL_ISSUE -- requirements
Module: mul_issue

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, the response buffer depth and the issue credit limit.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pause  input  1  global pipeline freeze, shared with the multiplier.
REQ-005 SHALL have port flush  input  1  discard all in-flight and buffered operations.
REQ-006 SHALL have port req_valid  input  1  a multiply request is present.
REQ-007 SHALL have port req_ready  output  1  the request is accepted this cycle.
REQ-008 SHALL have port req_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-009 SHALL have ports req_rs1 and req_rs2  input  32 each  the operands.
REQ-010 SHALL have port req_rd  input  5  the destination tag.
REQ-011 SHALL have ports mul_en, mac_low and mac_high  output  1 each  multiplier strobes.
REQ-012 SHALL have ports din1 and din2  output  33 each  sign-extended operands.
REQ-013 SHALL have ports dlout and dhout  input  32 each  multiplier low and high results.
REQ-014 SHALL have ports vldout and vhdout  input  1 each  multiplier result valids.
REQ-015 SHALL have port rsp_valid  output  1  a response is available.
REQ-016 SHALL have port rsp_ready  input  1  the consumer accepts the response.
REQ-017 SHALL have port rsp_data  output  32  the response result.
REQ-018 SHALL have port rsp_rd  output  5  the response destination tag.
REQ-019 SHALL have port busy  output  1  an operation is in flight or buffered.

Function
REQ-020 SHALL define issue = req_valid & req_ready; a request is accepted on the rising edge that ends a cycle in which issue=1.
REQ-021 SHALL drive the strobes combinationally: mul_en=issue; mac_low=issue & op==MUL; mac_high=issue & op!=MUL.
REQ-022 SHALL form din1 = {s1 & rs1[31], rs1} and din2 = {s2 & rs2[31], rs2}.
REQ-023 SHALL set s1=1 for MULH and MULHSU, else 0.
REQ-024 SHALL set s2=1 for MULH only, else 0.
REQ-025 SHALL drive din1 and din2 to 0 when issue=0.
REQ-026 SHALL expect latency from the issue cycle T: a low result arrives with vldout in T+1 and a high result with vhdout in T+2, with pause cycles stretching both.
REQ-027 SHALL track each issued op with its rd and kind in a 2-stage tag pipe that advances only when pause=0.
REQ-028 SHALL push {dlout, tag} into the response FIFO on vldout, and {dhout, tag} on vhdout.
REQ-029 SHALL ignore vldout and vhdout when no matching tag-pipe entry is valid.
REQ-030 SHALL deassert req_ready while pause=1, flush=1 or reset=1.
REQ-031 SHALL deassert req_ready while in-flight count plus FIFO count is greater than or equal to FIFO_DEPTH, so that results are never dropped.
REQ-032 SHALL deassert req_ready for a MUL request in the cycle immediately after a high-op issue, so that vldout and vhdout never coincide; a high-op request in that cycle is allowed.
REQ-033 SHALL keep responses in issue order.
REQ-034 SHALL present the FIFO head on rsp_valid, rsp_data and rsp_rd; it pops on rsp_valid & rsp_ready.
REQ-035 SHALL keep the response side independent of pause.
REQ-036 SHALL make a result visible at the earliest in the cycle after its vldout or vhdout; there is no bypass.
REQ-037 SHALL handle a simultaneous push and pop when full or empty: the count is unchanged and the data is correct.
REQ-038 SHALL on flush clear the tag pipe and the FIFO at the next edge; multiplier results returning afterwards are ignored; a request presented during flush is not accepted.
REQ-039 SHALL drive busy = (tag pipe non-empty) | (FIFO non-empty).

Reset
REQ-040 SHALL on reset clear the FIFO pointers, the count and the tag pipe.
REQ-041 SHALL hold after reset: rsp_valid=0, req_ready=0 during reset, busy=0, and all multiplier strobes 0.
REQ-042 SHALL treat reset mid-operation like flush: no stale response ever appears.
REQ-043 SHALL drive rsp_data and rsp_rd to 0 while rsp_valid=0.

Verification
REQ-044 SHALL cover: MUL rs1=7, rs2=0xFFFFFFFD, rd=5 -> din2[32]=0; rsp_data=0xFFFFFFEB, rsp_rd=5, rsp_valid in T+2.
REQ-045 SHALL cover: MULH 0x80000000 x 0x80000000 -> rsp_data=0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; each at T+3.
REQ-046 SHALL cover: MULHU issued in T, MUL presented in T+1 -> req_ready=0 in T+1, MUL accepted in T+2; responses arrive in order with no lost result.
REQ-047 SHALL cover: rsp_ready=0 with back-to-back requests -> exactly 2 accepted, req_ready stays 0; rsp_ready=1 -> both drain in order, then issue resumes.
REQ-048 SHALL cover: pause=1 for 3 cycles right after a MULH issue -> no push during pause; result pushed 2 unpaused cycles after issue; req_ready=0 throughout pause.
REQ-049 SHALL cover: flush (and separately reset) one cycle after a MUL issue -> rsp_valid never asserts for it, busy=0 the next cycle.
